// File: rtl/block_averager.sv
// Averages blocks of 2^LOG2_N unsigned 32-bit samples and tracks the block maximum.
// Receives and sends over active-low dav_ / active-high rfd four-phase handshakes; all outputs registered.
module block_averager #(
  parameter int LOG2_N = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dav_in_,
  input  logic [31:0] d_in,
  output logic        rfd_out,
  output logic        dav_out_,
  input  logic        rfd_in,
  output logic [31:0] avg,
  output logic [31:0] max
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 32 + LOG2_N;
  localparam int CW = LOG2_N + 1;

  typedef enum logic [2:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    P1 = 3'd2,
    P2 = 3'd3
  } state_e;

  state_e        star_q;
  logic [SW-1:0] sum_q,  sum_d;
  logic [31:0]   maxr_q, maxr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          rfd_q;
  logic          dav_q;
  logic [31:0]   avg_q;
  logic [31:0]   max_q;

  always_comb begin
    sum_d  = sum_q + SW'(d_in);
    maxr_d = (d_in > maxr_q) ? d_in : maxr_q;
    cnt_d  = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      star_q <= R0;
      sum_q  <= '0;
      maxr_q <= '0;
      cnt_q  <= '0;
      rfd_q  <= 1'b1;
      dav_q  <= 1'b1;
      avg_q  <= '0;
      max_q  <= '0;
    end else begin
      case (star_q)
        R0: begin
          if (!dav_in_) begin
            sum_q  <= sum_d;
            maxr_q <= maxr_d;
            cnt_q  <= cnt_d;
            rfd_q  <= 1'b0;
            star_q <= R1;
          end
        end
        R1: begin
          // Wait for upstream to release so a long dav_in_ pulse counts once.
          if (dav_in_) begin
            if (cnt_q == CW'(N)) begin
              avg_q  <= sum_q[SW-1:LOG2_N];
              max_q  <= maxr_q;
              sum_q  <= '0;
              maxr_q <= '0;
              cnt_q  <= '0;
              dav_q  <= 1'b0;
              star_q <= P1;
            end else begin
              rfd_q  <= 1'b1;
              star_q <= R0;
            end
          end
        end
        P1: begin
          if (!rfd_in) begin
            dav_q  <= 1'b1;
            star_q <= P2;
          end
        end
        P2: begin
          if (rfd_in) begin
            rfd_q  <= 1'b1;
            star_q <= R0;
          end
        end
        default: begin
          star_q <= R0;
          sum_q  <= '0;
          maxr_q <= '0;
          cnt_q  <= '0;
          rfd_q  <= 1'b1;
          dav_q  <= 1'b1;
          avg_q  <= '0;
          max_q  <= '0;
        end
      endcase
    end
  end

  assign rfd_out  = rfd_q;
  assign dav_out_ = dav_q;
  assign avg      = avg_q;
  assign max      = max_q;

endmodule

// File: doc/block_averager.md
Name: block_averager

Overview:
- Downstream consumer of the squared-sum acquisition stage.
- Takes its 32-bit results over a dav_/rfd handshake, where this block is the receiver.
- Accumulates blocks of N = 2^LOG2_N samples and tracks the block maximum.
- Per block, presents the truncated mean and the maximum to the next stage over a second dav_/rfd handshake, where this block is the sender.

Parameters:
- LOG2_N, 2, log2 of block length N; legal range 0..4, so N = 1..16.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dav_in_  input  1  upstream data-valid, active low.
- d_in  input  32  upstream sample; valid while dav_in_ = 0.
- rfd_out  output  1  ready-for-data to upstream, active high.
- dav_out_  output  1  data-valid to downstream, active low.
- rfd_in  input  1  ready-for-data from downstream, active high.
- avg  output  32  block mean, floor(sum / N).
- max  output  32  largest sample in the block, unsigned.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high.
- All outputs are registered. Internal registers:
  - SUM, 32+LOG2_N bits.
  - MAXR, 32 bits.
  - CNT, LOG2_N+1 bits.
  - STAR, 3 bits.
- Reset (asynchronous, any state, any time): rfd_out=1, dav_out_=1, avg=0, max=0, SUM=0, MAXR=0, CNT=0, STAR=R0.
  - A partial block is discarded.
  - A pending output is withdrawn, because dav_out_ returns to 1.
- States:
  - R0 (wait sample): if dav_in_=0 at the edge, then SUM<=SUM+d_in, MAXR<=max(MAXR,d_in) unsigned, CNT<=CNT+1, rfd_out<=0, go R1. Otherwise stay.
  - R1 (wait release): if dav_in_=1:
    - if CNT=N: avg<=SUM[31+LOG2_N:LOG2_N], max<=MAXR, SUM<=0, MAXR<=0, CNT<=0, dav_out_<=0, go P1;
    - else rfd_out<=1, go R0.
    - Otherwise stay.
  - P1 (wait ack): if rfd_in=0, then dav_out_<=1, go P2. Otherwise stay.
  - P2 (wait ready): if rfd_in=1, then rfd_out<=1, go R0. Otherwise stay.
- d_in is sampled only in R0, on the edge where dav_in_=0. Its value at any other time is ignored.
- Back-pressure: rfd_out stays 0 from sample capture through P2. Upstream cannot deliver the next sample until the result has been consumed.
- Arithmetic:
  - SUM cannot overflow: at most 16 × (2^32−1) < 2^36.
  - avg truncates toward zero; there is no rounding.
  - With LOG2_N=0, avg = max = the sample.
- Latency: dav_out_ falls on the first edge after the Nth sample's dav_in_ is seen high, i.e. 1 cycle after the upstream release.
- avg and max are stable from the fall of dav_out_ until the next block completes.
- Unused STAR encodings go to R0 with the reset values.
- dav_in_ held low across several cycles counts as one sample. A sample is counted only once its R0→R1 capture happens.

Test Plan:
- Reset mid-block: send 10, 20, then assert reset for 1 cycle.
  - Required: rfd_out=1, dav_out_=1, avg=0, max=0 immediately, without waiting for a clock edge.
  - Then send 1,1,1,1: avg=1, max=1, confirming the partial sum was discarded.
- Nominal block, LOG2_N=2: send 10, 40, 30, 20 with a full handshake each.
  - Required: dav_out_ falls 1 cycle after the 4th dav_in_ rise, with avg=25 and max=40.
  - Then rfd_in low → dav_out_ high 1 cycle later.
- Truncation: send 1, 1, 1, 2 → avg=1 (5>>2), max=2.
- Width limit: send 4 × 0xFFFFFFFF → avg=0xFFFFFFFF, max=0xFFFFFFFF, with no wrap.
- Back-pressure:
  - After dav_out_=0, hold rfd_in=1 for 20 cycles while upstream presents a 5th sample with dav_in_=0.
  - Required: rfd_out stays 0, the sample is not captured, and avg and max are unchanged.
  - After rfd_in 0→1, rfd_out=1 and the sample is captured as the first of the new block.
- LOG2_N=0 build: send 7, then 3 → two outputs, avg=max=7 and then avg=max=3, each following its own handshake.
